cplx_mac_pe: RTL and testbench

Parametrised successor to the complex-MAC processing element used in the systolic CNN array. Accepts packed complex activations (imap) and weights (fmap) with a valid qualifier, and forwards them to the neighbour PE with fixed 1-cycle latency. Accumulates a programmable number of complex products into wide signed accumulators. Emits each finished partial sum through a valid/ready output register, so the accumulator restarts while the previous result drains.

---
 rtl/cnn_pe_pkg.sv | 50 +++++
 rtl/cplx_mult.sv | 24 ++
 rtl/cplx_mac_pe.sv | 122 ++++++++++++
 tb/tb_cplx_mac_pe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pe_pkg.sv
// Shared types and helpers for the complex-MAC processing elements.
// Helpers work on MAX_W-wide containers and take the real component width as an argument.
package cnn_pe_pkg;

    localparam int MAX_W = 64;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

    // Real component (low half) of a packed complex value, sign-extended.
    function automatic logic signed [MAX_W-1:0] get_re(input logic [2*MAX_W-1:0] v, input int w);
        logic signed [2*MAX_W-1:0] t;
        t = $signed(v << (2*MAX_W - w));
        t = t >>> (2*MAX_W - w);
        return t[MAX_W-1:0];
    endfunction

    function automatic logic signed [MAX_W-1:0] get_im(input logic [2*MAX_W-1:0] v, input int w);
        logic signed [2*MAX_W-1:0] t;
        t = $signed(v << (2*MAX_W - 2*w));
        t = t >>> (2*MAX_W - w);
        return t[MAX_W-1:0];
    endfunction

    function automatic logic [2*MAX_W-1:0] pack(input logic signed [MAX_W-1:0] re,
                                                input logic signed [MAX_W-1:0] im,
                                                input int w);
        logic [2*MAX_W-1:0] mask;
        mask = (128'd1 << w) - 128'd1;
        return ((128'(im) & mask) << w) | (128'(re) & mask);
    endfunction

    // Signed add clamped to the range of a w-bit two's-complement value.
    function automatic logic signed [MAX_W-1:0] sat_add(input logic signed [MAX_W-1:0] a,
                                                        input logic signed [MAX_W-1:0] b,
                                                        input int w);
        logic signed [MAX_W:0] s, hi, lo;
        s  = {a[MAX_W-1], a} + {b[MAX_W-1], b};
        hi = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (w - 1));
        if (s > hi)
            return hi[MAX_W-1:0];
        else if (s < lo)
            return lo[MAX_W-1:0];
        return s[MAX_W-1:0];
    endfunction

endpackage

// File: rtl/cplx_mult.sv
// Combinational signed complex multiply; products kept at full 2*DATA_W+1 precision.
module cplx_mult
    import cnn_pe_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [2*DATA_W-1:0]   imap,
    input  logic [2*DATA_W-1:0]   fmap,
    output logic signed [2*DATA_W:0] p_re,
    output logic signed [2*DATA_W:0] p_im
);

    logic signed [2*DATA_W:0] ir, ii, fr, fi;

    assign ir = (2*DATA_W+1)'(get_re((2*MAX_W)'(imap), DATA_W));
    assign ii = (2*DATA_W+1)'(get_im((2*MAX_W)'(imap), DATA_W));
    assign fr = (2*DATA_W+1)'(get_re((2*MAX_W)'(fmap), DATA_W));
    assign fi = (2*DATA_W+1)'(get_im((2*MAX_W)'(fmap), DATA_W));

    // Operands are pre-extended so each product is exact before the final add/sub.
    assign p_re = fr * ir - fi * ii;
    assign p_im = fr * ii + fi * ir;

endmodule

// File: rtl/cplx_mac_pe.sv
// Complex MAC processing element: 1-cycle forwarding, ACC_LEN-beat accumulation, valid/ready result.
// Define CNN_PE_SAT_EN for saturating accumulation instead of two's-complement wrap.
module cplx_mac_pe
    import cnn_pe_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ACC_W   = 40,
    parameter int ACC_LEN = 9,
    parameter int CNT_W   = $clog2(ACC_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [2*DATA_W-1:0]   in_imap,
    input  logic [2*DATA_W-1:0]   in_fmap,
    input  logic                  acc_clr,
    output logic                  out_valid,
    output logic [2*DATA_W-1:0]   out_imap,
    output logic [2*DATA_W-1:0]   out_fmap,
    output logic                  omap_valid,
    input  logic                  omap_ready,
    output logic [2*ACC_W-1:0]    omap,
    output logic                  ovf
);

    logic signed [2*DATA_W:0] p_re, p_im;
    logic signed [ACC_W-1:0]  acc_re, acc_im, prod_re, prod_im, sum_re, sum_im;
    logic [CNT_W-1:0]         cnt;
    logic                     last_beat, load, ovf_set;
    out_state_e               state_q, state_d;

    cplx_mult #(.DATA_W(DATA_W)) u_mult (
        .imap (in_imap),
        .fmap (in_fmap),
        .p_re (p_re),
        .p_im (p_im)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_imap  <= '0;
            out_fmap  <= '0;
        end else begin
            out_valid <= in_valid;
            out_imap  <= in_imap;
            out_fmap  <= in_fmap;
        end
    end

    assign prod_re = ACC_W'(p_re);
    assign prod_im = ACC_W'(p_im);

`ifdef CNN_PE_SAT_EN
    assign sum_re = ACC_W'(sat_add(MAX_W'(acc_re), MAX_W'(prod_re), ACC_W));
    assign sum_im = ACC_W'(sat_add(MAX_W'(acc_im), MAX_W'(prod_im), ACC_W));
`else
    assign sum_re = acc_re + prod_re;
    assign sum_im = acc_im + prod_im;
`endif

    assign last_beat = in_valid && !acc_clr && (cnt == CNT_W'(ACC_LEN - 1));

    // The finishing beat hands its sum to omap and restarts the accumulator in the same edge.
    always_ff @(posedge clk) begin
        if (rst || acc_clr) begin
            acc_re <= '0;
            acc_im <= '0;
            cnt    <= '0;
        end else if (in_valid) begin
            if (last_beat) begin
                acc_re <= '0;
                acc_im <= '0;
                cnt    <= '0;
            end else begin
                acc_re <= sum_re;
                acc_im <= sum_im;
                cnt    <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovf_set = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (last_beat) begin
                    state_d = OUT_FULL;
                    load    = 1'b1;
                end
            end
            OUT_FULL: begin
                if (omap_ready) begin
                    load    = last_beat;
                    state_d = last_beat ? OUT_FULL : OUT_EMPTY;
                end else if (last_beat) begin
                    ovf_set = 1'b1;
                end
            end
            default: state_d = OUT_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OUT_EMPTY;
            omap    <= '0;
            ovf     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load)
                omap <= (2*ACC_W)'(pack(MAX_W'(sum_re), MAX_W'(sum_im), ACC_W));
            if (ovf_set)
                ovf <= 1'b1;
        end
    end

    assign omap_valid = (state_q == OUT_FULL);

endmodule

// File: tb/tb_cplx_mac_pe.sv
// Five PE configurations share one stimulus stream and are checked against an arithmetic model.
module tb_cplx_mac_pe;

    localparam int NPE = 5;

    function automatic int len_of(input int k);
        return (k == 0) ? 9 : (k == 1) ? 2 : (k == 2) ? 1 : (k == 3) ? 3 : 4;
    endfunction

    function automatic int aw_of(input int k);
        return (k == 4) ? 33 : 40;
    endfunction

    logic        clk = 1'b0;
    logic        rst, in_valid, acc_clr, omap_ready;
    logic [31:0] in_imap, in_fmap;

    logic        ov[NPE], mv[NPE], ovfv[NPE];
    logic [31:0] oi[NPE], of[NPE];
    logic [127:0] om[NPE];

    always #5 clk = ~clk;

    for (genvar k = 0; k < NPE; k++) begin : g_pe
        localparam int LEN = len_of(k);
        localparam int AW  = aw_of(k);
        logic [2*AW-1:0] om_k;
        cplx_mac_pe #(.DATA_W(16), .ACC_W(AW), .ACC_LEN(LEN)) dut (
            .clk        (clk),
            .rst        (rst),
            .in_valid   (in_valid),
            .in_imap    (in_imap),
            .in_fmap    (in_fmap),
            .acc_clr    (acc_clr),
            .out_valid  (ov[k]),
            .out_imap   (oi[k]),
            .out_fmap   (of[k]),
            .omap_valid (mv[k]),
            .omap_ready (omap_ready),
            .omap       (om_k),
            .ovf        (ovfv[k])
        );
        assign om[k] = 128'(om_k);
    end

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [127:0] cpk(input longint re, input longint im, input int w);
        logic [127:0] mask;
        mask = (128'd1 << w) - 128'd1;
        return ((128'(im) & mask) << w) | (128'(re) & mask);
    endfunction

    function automatic logic [31:0] cin(input int re, input int im);
        logic [31:0] r, i;
        r = 32'(re);
        i = 32'(im);
        return {i[15:0], r[15:0]};
    endfunction

    function automatic longint fit(input longint x, input int w);
        longint m, v;
        m = 64'sd1 <<< w;
`ifdef CNN_PE_SAT_EN
        v = x;
        if (x > m / 2 - 1) v = m / 2 - 1;
        if (x < -(m / 2)) v = -(m / 2);
`else
        v = x & (m - 1);
        if (v >= m / 2) v = v - m;
`endif
        return v;
    endfunction

    // Reference model: mathematical complex sums, results queued into a one-deep output slot.
    longint m_re[NPE], m_im[NPE], m_ore[NPE], m_oim[NPE];
    int     m_cnt[NPE];
    bit     m_full[NPE], m_ovf[NPE];
    bit          f_v;
    logic [31:0] f_i, f_f;

    always @(posedge clk) begin
        longint ar, ai, fr, fi, pr, pi;
        ar = longint'($signed(in_imap[15:0]));
        ai = longint'($signed(in_imap[31:16]));
        fr = longint'($signed(in_fmap[15:0]));
        fi = longint'($signed(in_fmap[31:16]));
        pr = fr * ar - fi * ai;
        pi = fr * ai + fi * ar;
        for (int k = 0; k < NPE; k++) begin
            if (rst) begin
                m_re[k] = 0; m_im[k] = 0; m_ore[k] = 0; m_oim[k] = 0;
                m_cnt[k] = 0; m_full[k] = 0; m_ovf[k] = 0;
            end else begin
                if (m_full[k] && omap_ready) m_full[k] = 0;
                if (acc_clr) begin
                    m_re[k] = 0; m_im[k] = 0; m_cnt[k] = 0;
                end else if (in_valid) begin
                    m_re[k] = fit(m_re[k] + pr, aw_of(k));
                    m_im[k] = fit(m_im[k] + pi, aw_of(k));
                    m_cnt[k]++;
                    if (m_cnt[k] == len_of(k)) begin
                        if (!m_full[k]) begin
                            m_full[k] = 1;
                            m_ore[k] = m_re[k];
                            m_oim[k] = m_im[k];
                        end else begin
                            m_ovf[k] = 1;
                        end
                        m_re[k] = 0; m_im[k] = 0; m_cnt[k] = 0;
                    end
                end
            end
        end
        if (rst) begin
            f_v = 0; f_i = '0; f_f = '0;
        end else begin
            f_v = in_valid; f_i = in_imap; f_f = in_fmap;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < NPE; k++) begin
                check($sformatf("omap_valid[%0d]", k), 128'(mv[k]), 128'(m_full[k]));
                check($sformatf("omap[%0d]", k), om[k], cpk(m_ore[k], m_oim[k], aw_of(k)));
                check($sformatf("ovf[%0d]", k), 128'(ovfv[k]), 128'(m_ovf[k]));
            end
            check("out_valid", 128'(ov[0]), 128'(f_v));
            check("out_imap", 128'(oi[0]), 128'(f_i));
            check("out_fmap", 128'(of[0]), 128'(f_f));
        end
    end

    task automatic step(input bit v, input logic [31:0] im, input logic [31:0] fm,
                        input bit clr, input bit rdy, input bit r);
        in_valid   = v;
        in_imap    = im;
        in_fmap    = fm;
        acc_clr    = clr;
        omap_ready = rdy;
        rst        = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step(0, '0, '0, 0, 0, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_imap = '0; in_fmap = '0;
        acc_clr = 1'b0; omap_ready = 1'b0;
        do_reset();
        chk_en = 1;
        for (int k = 0; k < NPE; k++) begin
            check($sformatf("rst_omap_valid[%0d]", k), 128'(mv[k]), 128'd0);
            check($sformatf("rst_omap[%0d]", k), om[k], 128'd0);
        end

        // ACC_LEN=2 basic sum, then a second identical pair to show the accumulator restarted.
        step(1, cin(3, 2), cin(1, 4), 0, 1, 0);
        check("t1_valid_early", 128'(mv[1]), 128'd0);
        step(1, cin(3, 2), cin(1, 4), 0, 1, 0);
        check("t1_valid", 128'(mv[1]), 128'd1);
        check("t1_omap", om[1], cpk(-10, 28, 40));
        step(0, '0, '0, 0, 1, 0);
        check("t1_valid_drop", 128'(mv[1]), 128'd0);
        step(1, cin(3, 2), cin(1, 4), 0, 1, 0);
        step(1, cin(3, 2), cin(1, 4), 0, 1, 0);
        check("t1_omap_again", om[1], cpk(-10, 28, 40));

        // Back-pressure on ACC_LEN=1.
        do_reset();
        step(1, cin(1, 0), cin(5, 0), 0, 0, 0);
        check("bp_omap1", om[2], cpk(5, 0, 40));
        step(1, cin(1, 0), cin(7, 0), 0, 0, 0);
        check("bp_omap_held", om[2], cpk(5, 0, 40));
        check("bp_ovf", 128'(ovfv[2]), 128'd1);
        step(0, '0, '0, 0, 1, 0);
        check("bp_valid_after_hs", 128'(mv[2]), 128'd0);
        check("bp_ovf_sticky", 128'(ovfv[2]), 128'd1);

        // acc_clr on ACC_LEN=3 discards the partial sum and the coincident beat.
        do_reset();
        step(1, cin(2, 0), cin(2, 0), 0, 1, 0);
        step(1, cin(2, 0), cin(2, 0), 1, 1, 0);
        repeat (3) step(1, cin(1, 0), cin(1, 0), 0, 1, 0);
        check("clr_valid", 128'(mv[3]), 128'd1);
        check("clr_omap", om[3], cpk(3, 0, 40));

        // Extreme operands on ACC_W=33, ACC_LEN=4.
        do_reset();
        repeat (4) step(1, cin(-32768, -32768), cin(-32768, -32768), 0, 1, 0);
        check("ext_valid", 128'(mv[4]), 128'd1);
`ifdef CNN_PE_SAT_EN
        check("ext_omap", om[4], cpk(0, (64'sd1 <<< 32) - 1, 33));
`else
        check("ext_omap", om[4], cpk(0, 0, 33));
`endif

        // Reset mid-accumulation while a result is pending.
        do_reset();
        step(1, cin(3, 2), cin(1, 4), 0, 0, 0);
        step(1, cin(3, 2), cin(1, 4), 0, 0, 0);
        step(1, cin(3, 2), cin(1, 4), 0, 0, 0);
        check("mr_valid_before", 128'(mv[1]), 128'd1);
        step(1, cin(3, 2), cin(1, 4), 0, 0, 1);
        check("mr_valid", 128'(mv[1]), 128'd0);
        check("mr_omap", om[1], 128'd0);
        check("mr_ovf", 128'(ovfv[1]), 128'd0);
        check("mr_out_valid", 128'(ov[1]), 128'd0);
        check("mr_out_imap", 128'(oi[1]), 128'd0);
        check("mr_out_fmap", 128'(of[1]), 128'd0);
        step(1, cin(3, 2), cin(1, 4), 0, 1, 0);
        step(1, cin(3, 2), cin(1, 4), 0, 1, 0);
        check("mr_fresh_omap", om[1], cpk(-10, 28, 40));

        // Randomized traffic against the model.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, $urandom,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 6,
                 $urandom_range(0, 149) == 0);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
